spi_req_arbiter: RTL and testbench
==================================

# spi_req_arbiter

Shares the single SPI master controller between two transfer requesters: requester 0 (memory-mapped flash path, `axi2spi_req`/`spi2axi_ack`) and requester 1 (register-initiated transfers, `reg2spi_req`/`spi2reg_ack`). It arbitrates with either round-robin or fixed priority and latches the winner's transfer configuration. It drives the controller through a four-phase req/ack handshake and returns completion, or a timeout error, to the granted requester only. It sits between the AXI register interface and the SPI master controller, inside the SPI master top level.

## Interface
- `CFG_W`, default 128: width of the opaque transfer-configuration bundle (cmd, cmd_len, addr, addr_len, data_len, dummy counts, rd/wr/qrd/qwr, csreg), concatenated by the integrator.
- `FIXED_PRIO`, default 0: 0 selects round-robin; 1 means requester 0 always wins ties.
- `TIMEOUT_CYCLES`, default 0: maximum number of cycles in S_REQ before error abort. 0 disables the timeout.

Ports:
- `s_axi_aclk` in 1: clock.
- `s_axi_aresetn` in 1: reset; asynchronous, active-low; clock is `s_axi_aclk`.
- `swrst` in 1: synchronous soft reset, driven from `spi_swrst`.
- `r0_req` in 1: requester 0 transfer request (level).
- `r0_cfg` in CFG_W: requester 0 configuration; held stable while `r0_req` is high.
- `r0_ack` out 1: transfer done for requester 0.
- `r0_err` out 1: qualifies `r0_ack` as a timeout abort.
- `r1_req`, `r1_cfg`, `r1_ack`, `r1_err`: same as the requester 0 signals, for requester 1.
- `spi_req` out 1: request to the controller.
- `spi_cfg` out CFG_W: latched configuration of the granted requester.
- `spi_ack` in 1: controller completion (level).
- `grant` out 2: one-hot current owner; 00 when idle.
- `busy` out 1: high in every state except S_IDLE.
- `timeout` out 1: one-cycle pulse on timeout abort.

## Operation
- **Reset values.** Every output is 0 after reset. The state machine is in S_IDLE and the RR pointer is `last=1`, so requester 0 is favoured first.
- **States:** S_IDLE, S_REQ, S_ACK, S_REL.
- **S_IDLE**
  - If any `rN_req` is high, select a winner, latch `rN_cfg` into `spi_cfg`, set `grant`, and go to S_REQ.
  - Round-robin: when both requesters are requesting, the one not equal to `last` wins. `last` is updated at the grant.
  - `FIXED_PRIO=1`: requester 0 wins whenever `r0_req` is high.
  - A single requester always wins.
- **S_REQ**
  - `spi_req`=1.
  - On `spi_ack`=1: assert `rN_ack` for the granted requester and go to S_ACK.
  - Timeout: if `TIMEOUT_CYCLES`>0 and the cycle counter reaches `TIMEOUT_CYCLES`, assert `rN_ack` and `rN_err`, pulse `timeout`, drop `spi_req`, and go to S_ACK.
  - The cycle counter is 16 bits, cleared on entry to S_REQ, and saturating.
- **S_ACK**
  - `rN_ack` (and `rN_err`, if set) are held. `spi_req` stays 1 unless a timeout occurred.
  - When the granted `rN_req` is sampled low: clear `rN_ack`/`rN_err`, clear `spi_req`, and go to S_REL.
- **S_REL**
  - Wait for `spi_ack`=0, then clear `grant` and go to S_IDLE.
  - After a timeout, S_REL also waits for `spi_ack`=0. Software is expected to issue `swrst` if the controller is hung.
- **Configuration stability.** `spi_cfg` is held from the grant until the next grant. `rN_cfg` changes after the grant are ignored.
- **Non-granted requester.** Its `rN_ack`/`rN_err` are never asserted, and its `req` stays pending until it wins in S_IDLE.
- **Early withdrawal.** If the granted requester drops `req` while in S_REQ, this is a protocol violation and is ignored. The transfer completes and `rN_ack` pulses for one cycle, because S_ACK sees `req` low immediately.
- **`swrst`.** From any state, the next cycle returns the block to reset values (state, `last`, counter, and all outputs). `swrst` has priority over every other event.
- **Asynchronous reset mid-transfer.** Immediate return to reset values. No ack is issued.

## Timing
- All outputs are registered.
- Grant latency: `rN_req` high in S_IDLE at cycle N gives `spi_req`/`grant`/`spi_cfg` valid at N+1.
- Ack latency: `spi_ack` high at cycle M gives `rN_ack` high at M+1.
- Release: `rN_req` low at cycle K gives `rN_ack`=0 and `spi_req`=0 at K+1.
- Return to idle: `spi_ack` low at cycle L gives S_IDLE and `grant`=0 at L+1. The earliest next `spi_req` is at L+2.
- Timeout: the abort fires on the cycle after the counter equals `TIMEOUT_CYCLES`, so `spi_req` is high for exactly `TIMEOUT_CYCLES`+1 cycles.
- Simultaneous requests in the same S_IDLE cycle are resolved in that cycle. There is no combinational path from any input to any output.

## Test plan
- **Single request.** `r1_req`=1 with `cfg`=0xA5…; controller acks 5 cycles later.
  - `spi_req` at +1 with `spi_cfg`=0xA5….
  - `r1_ack` one cycle after `spi_ack`.
  - `grant`=10 throughout the transfer; `r0_ack` stays 0.
- **Round-robin.** `r0_req` and `r1_req` held high continuously for 4 transfers; grant order is r0, r1, r0, r1. With `FIXED_PRIO=1`, the order is r0, r0, r0, r0.
- **Config latch.** Change `r0_cfg` from 0x11 to 0x22 one cycle after the grant; `spi_cfg` stays 0x11 until S_IDLE.
- **Timeout.** With `TIMEOUT_CYCLES`=8 and `spi_ack` never asserted:
  - `spi_req` is high for exactly 9 cycles.
  - `timeout` pulses once; `r0_ack`=`r0_err`=1.
  - After `r0_req` drops, the block enters S_IDLE.
- **`swrst` mid-transfer.** Pulse `swrst` in S_ACK; at +1 all outputs are 0, state is S_IDLE, and the next simultaneous request grants r0.
- **Back-to-back.** `spi_ack` drops at cycle L with `r1_req` pending; `spi_req` rises again at L+2 for r1.

Source files
------------

// File: rtl/spi_req_arbiter_if.sv
// Handshake bundle between the two SPI transfer requesters, the arbiter and the SPI master controller.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface spi_req_arbiter_if #(
  parameter int CFG_W = 128
);
  logic             r0_req;
  logic [CFG_W-1:0] r0_cfg;
  logic             r0_ack;
  logic             r0_err;
  logic             r1_req;
  logic [CFG_W-1:0] r1_cfg;
  logic             r1_ack;
  logic             r1_err;
  logic             spi_req;
  logic [CFG_W-1:0] spi_cfg;
  logic             spi_ack;
  logic [1:0]       grant;
  logic             busy;
  logic             timeout;

  modport slave (
    input  r0_req, r0_cfg, r1_req, r1_cfg, spi_ack,
    output r0_ack, r0_err, r1_ack, r1_err, spi_req, spi_cfg, grant, busy, timeout
  );

  modport master (
    output r0_req, r0_cfg, r1_req, r1_cfg, spi_ack,
    input  r0_ack, r0_err, r1_ack, r1_err, spi_req, spi_cfg, grant, busy, timeout
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Two-requester arbiter for the shared SPI master controller: round-robin or fixed priority,
// latched transfer configuration, four-phase req/ack to the controller and optional timeout abort.
module spi_req_arbiter #(
  parameter int CFG_W          = 128,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               s_axi_aclk,
  input  logic               s_axi_aresetn,
  input  logic               swrst,
  spi_req_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_REL} state_t;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  localparam bit          TO_EN  = (TIMEOUT_CYCLES > 0);

  state_t           r_state, w_stateNxt;
  logic             r_last, w_lastNxt;
  logic [15:0]      r_cnt, w_cntNxt;
  logic [1:0]       r_grant, w_grantNxt;
  logic             r_spiReq, w_spiReqNxt;
  logic [CFG_W-1:0] r_spiCfg, w_spiCfgNxt;
  logic [1:0]       r_ack, w_ackNxt;
  logic [1:0]       r_err, w_errNxt;
  logic             r_timeout, w_timeoutNxt;

  logic             w_ownReq;
  logic             w_pick1;

  assign w_ownReq = r_grant[1] ? bus.r1_req : bus.r0_req;

  // r_last=1 favours requester 0 on a tie; a lone requester always wins.
  always_comb begin
    if (FIXED_PRIO != 0) w_pick1 = !bus.r0_req;
    else                 w_pick1 = bus.r1_req && (!bus.r0_req || !r_last);
  end

  always_comb begin
    w_stateNxt   = r_state;
    w_lastNxt    = r_last;
    w_cntNxt     = r_cnt;
    w_grantNxt   = r_grant;
    w_spiReqNxt  = r_spiReq;
    w_spiCfgNxt  = r_spiCfg;
    w_ackNxt     = r_ack;
    w_errNxt     = r_err;
    w_timeoutNxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          w_stateNxt  = S_REQ;
          w_grantNxt  = w_pick1 ? 2'b10 : 2'b01;
          w_spiCfgNxt = w_pick1 ? bus.r1_cfg : bus.r0_cfg;
          w_spiReqNxt = 1'b1;
          w_cntNxt    = '0;
          w_lastNxt   = w_pick1;
        end
      end
      // A genuine completion wins over a timeout landing in the same cycle.
      S_REQ: begin
        if (bus.spi_ack) begin
          w_ackNxt   = r_grant;
          w_stateNxt = S_ACK;
        end else if (TO_EN && (r_cnt == TO_LIM)) begin
          w_ackNxt     = r_grant;
          w_errNxt     = r_grant;
          w_timeoutNxt = 1'b1;
          w_spiReqNxt  = 1'b0;
          w_stateNxt   = S_ACK;
        end else if (r_cnt != 16'hFFFF) begin
          w_cntNxt = r_cnt + 16'd1;
        end
      end
      S_ACK: begin
        if (!w_ownReq) begin
          w_ackNxt    = '0;
          w_errNxt    = '0;
          w_spiReqNxt = 1'b0;
          w_stateNxt  = S_REL;
        end
      end
      S_REL: begin
        if (!bus.spi_ack) begin
          w_grantNxt = '0;
          w_stateNxt = S_IDLE;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  // Soft reset restores exactly the same values as the asynchronous reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_spiReq  <= 1'b0;
      r_spiCfg  <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else if (swrst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_spiReq  <= 1'b0;
      r_spiCfg  <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_last    <= w_lastNxt;
      r_cnt     <= w_cntNxt;
      r_grant   <= w_grantNxt;
      r_spiReq  <= w_spiReqNxt;
      r_spiCfg  <= w_spiCfgNxt;
      r_ack     <= w_ackNxt;
      r_err     <= w_errNxt;
      r_timeout <= w_timeoutNxt;
    end
  end

  assign bus.r0_ack  = r_ack[0];
  assign bus.r1_ack  = r_ack[1];
  assign bus.r0_err  = r_err[0];
  assign bus.r1_err  = r_err[1];
  assign bus.spi_req = r_spiReq;
  assign bus.spi_cfg = r_spiCfg;
  assign bus.grant   = r_grant;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: instance A is round-robin with an 8-cycle timeout,
// instance B is fixed priority; both share the stimulus, each has its own reset.
module tb_spi_req_arbiter;

  logic         clk = 1'b0;
  logic         rstnA = 1'b0;
  logic         rstnB = 1'b0;
  logic         swrst = 1'b0;
  logic         r0Req = 1'b0;
  logic         r1Req = 1'b0;
  logic         spiAck = 1'b0;
  logic [127:0] r0Cfg = '0;
  logic [127:0] r1Cfg = '0;
  logic         selB = 1'b0;
  int           nCompared = 0;
  int           nMismatched = 0;

  spi_req_arbiter_if #(.CFG_W(128)) busA ();
  spi_req_arbiter_if #(.CFG_W(128)) busB ();

  assign busA.r0_req  = r0Req;
  assign busA.r1_req  = r1Req;
  assign busA.r0_cfg  = r0Cfg;
  assign busA.r1_cfg  = r1Cfg;
  assign busA.spi_ack = spiAck;
  assign busB.r0_req  = r0Req;
  assign busB.r1_req  = r1Req;
  assign busB.r0_cfg  = r0Cfg;
  assign busB.r1_cfg  = r1Cfg;
  assign busB.spi_ack = spiAck;

  spi_req_arbiter #(.CFG_W(128), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dutA (
    .s_axi_aclk(clk), .s_axi_aresetn(rstnA), .swrst(swrst), .bus(busA)
  );

  spi_req_arbiter #(.CFG_W(128), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0)) dutB (
    .s_axi_aclk(clk), .s_axi_aresetn(rstnB), .swrst(swrst), .bus(busB)
  );

  always #5 clk = ~clk;

  logic [1:0] obsGrant;
  logic [1:0] obsAck;
  logic [7:0] allOutsA;
  assign obsGrant = selB ? busB.grant : busA.grant;
  assign obsAck   = selB ? {busB.r1_ack, busB.r0_ack} : {busA.r1_ack, busA.r0_ack};
  assign allOutsA = {busA.spi_req, busA.grant, busA.busy, busA.r0_ack, busA.r0_err,
                     busA.r1_ack, busA.r1_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req0, input logic req1, input logic ack);
    r0Req  = req0;
    r1Req  = req1;
    spiAck = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Both requests are high and the DUT is idle on entry; same on exit.
  task automatic runPair(input logic [1:0] expGrant, input string tag);
    tick();
    checkOutput({tag, "_grant"}, obsGrant, expGrant);
    spiAck = 1'b1;
    tick();
    checkOutput({tag, "_ack"}, obsAck, expGrant);
    if (expGrant == 2'b01) r0Req = 1'b0;
    else                   r1Req = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput({tag, "_idle"}, obsGrant, 2'b00);
  endtask

  initial begin
    int highCnt;
    int toCnt;

    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_outs", {allOutsA, busA.timeout}, 9'd0);
    checkOutput("rst_cfg", busA.spi_cfg, 128'd0);
    rstnA = 1'b1;
    tick();

    $display("[TB] single request on r1");
    r1Cfg = {16{8'hA5}};
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("single_spireq", busA.spi_req, 1'b1);
    checkOutput("single_grant", busA.grant, 2'b10);
    checkOutput("single_cfg", busA.spi_cfg, {16{8'hA5}});
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("single_wait", {busA.grant, busA.r1_ack, busA.r0_ack}, 4'b1000);
    end
    spiAck = 1'b1;
    tick();
    checkOutput("single_ack", {busA.grant, busA.r1_ack, busA.r0_ack, busA.r1_err}, 5'b10100);
    r1Req = 1'b0;
    tick();
    checkOutput("single_rel", {busA.grant, busA.r1_ack, busA.spi_req}, 4'b1000);
    spiAck = 1'b0;
    tick();
    checkOutput("single_idle", {busA.grant, busA.busy}, 3'b000);

    $display("[TB] round-robin");
    applyStimulus(1'b1, 1'b1, 1'b0);
    runPair(2'b01, "rr0");
    runPair(2'b10, "rr1");
    runPair(2'b01, "rr2");
    runPair(2'b10, "rr3");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    $display("[TB] config latch");
    r0Cfg = 128'h11;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("cfg_grant", busA.spi_cfg, 128'h11);
    r0Cfg = 128'h22;
    tick();
    checkOutput("cfg_hold", busA.spi_cfg, 128'h11);
    spiAck = 1'b1;
    tick();
    checkOutput("cfg_ack", {busA.spi_cfg[7:0], busA.r0_ack}, {8'h11, 1'b1});
    r0Req = 1'b0;
    tick();
    spiAck = 1'b0;
    tick();
    checkOutput("cfg_idle", {busA.spi_cfg[7:0], busA.busy}, {8'h11, 1'b0});

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    highCnt = 0;
    toCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busA.timeout) toCnt++;
      if (!busA.spi_req) break;
      highCnt++;
      tick();
    end
    checkOutput("to_ackerr", {busA.r0_ack, busA.r0_err, busA.r1_ack, busA.r1_err}, 4'b1100);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busA.timeout) toCnt++;
    end
    checkOutput("to_high", highCnt, 9);
    checkOutput("to_pulse", toCnt, 1);
    r0Req = 1'b0;
    tick();
    checkOutput("to_rel", {busA.r0_ack, busA.r0_err, busA.spi_req}, 3'b000);
    tick();
    checkOutput("to_idle", {busA.busy, busA.grant}, 3'b000);

    $display("[TB] soft reset in S_ACK");
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    spiAck = 1'b1;
    tick();
    checkOutput("sw_preack", busA.r0_ack, 1'b1);
    swrst = 1'b1;
    spiAck = 1'b0;
    tick();
    swrst = 1'b0;
    checkOutput("sw_outs", {allOutsA, busA.timeout}, 9'd0);
    checkOutput("sw_cfg", busA.spi_cfg, 128'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("sw_rr", busA.grant, 2'b01);
    spiAck = 1'b1;
    tick();
    checkOutput("sw_ack", {busA.r1_ack, busA.r0_ack}, 2'b01);
    r0Req = 1'b0;
    tick();

    $display("[TB] back-to-back");
    spiAck = 1'b0;
    tick();
    checkOutput("b2b_l1", {busA.spi_req, busA.grant}, 3'b000);
    tick();
    checkOutput("b2b_l2", {busA.spi_req, busA.grant}, 3'b110);
    spiAck = 1'b1;
    tick();
    r1Req = 1'b0;
    tick();
    spiAck = 1'b0;
    tick();
    checkOutput("b2b_done", busA.busy, 1'b0);

    $display("[TB] fixed priority");
    rstnA = 1'b0;
    rstnB = 1'b1;
    selB = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    runPair(2'b01, "fp0");
    runPair(2'b01, "fp1");
    runPair(2'b01, "fp2");
    runPair(2'b01, "fp3");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
